// File: rtl/mul_div_unit.sv
// mul_div_unit
//
// RV32M execution unit fed by the multiply/divide reservation station. It
// holds one operation at a time and broadcasts its result for one cycle on
// the CDB multiply lane. Multiplies complete after a fixed MUL_LATENCY.
// Divides use a radix-2 restoring engine: one setup cycle, 32 iterations
// and one finalize cycle, for 34 cycles in total.
//
// Optional feature macro: MULDIV_DIV_EARLY_EN
//    When this macro is defined, divide-by-zero and signed overflow skip the
//    iteration loop and complete 2 cycles after accept.
//    When it is undefined, every divide takes 34 cycles.
//    The result values are the same in both builds.
//
// Parameters
//    MUL_LATENCY    cycles from accept to result for multiplies (1..4)
//    ROB_IDX_WIDTH  width of the ROB index tag
//
// Ports
//    clk            clock; all state changes on the rising edge
//    rst            synchronous, active-high reset
//    flush          synchronous abort of any in-flight operation
//    in_valid       operand-ready instruction is presented
//    in_ready       unit can accept this cycle
//    in_multop      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//    in_rs1_data    operand A
//    in_rs2_data    operand B
//    in_rd_addr     destination architectural register
//    in_rob_idx     destination ROB entry
//    resp_valid     one-cycle CDB valid pulse
//    resp_data      result; holds its value while resp_valid is low
//    resp_rd_addr   rd of the completed operation
//    resp_rob_idx   ROB index of the completed operation

module mul_div_unit #(
   parameter int MUL_LATENCY   = 2,
   parameter int ROB_IDX_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_multop,
   input  logic [31:0]              in_rs1_data,
   input  logic [31:0]              in_rs2_data,
   input  logic [4:0]               in_rd_addr,
   input  logic [ROB_IDX_WIDTH-1:0] in_rob_idx,
   output logic                     resp_valid,
   output logic [31:0]              resp_data,
   output logic [4:0]               resp_rd_addr,
   output logic [ROB_IDX_WIDTH-1:0] resp_rob_idx
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   // Divide step numbering: step 0 is setup, steps 1..32 iterate, and
   // step 33 applies the sign correction and publishes the result.
   localparam logic [1:0] MUL_CNT_INIT   = 2'(MUL_LATENCY - 1);
   localparam logic [5:0] DIV_FINAL_STEP = 6'd33;

   state_t                     state;
   state_t                     state_next;
   logic                       accept;

   logic [2:0]                 op;
   logic [31:0]                opa;
   logic [31:0]                opb;
   logic [4:0]                 op_rd;
   logic [ROB_IDX_WIDTH-1:0]   op_rob;

   logic [1:0]                 mul_cnt;
   logic [5:0]                 div_step;

   logic [31:0]                rem;
   logic [31:0]                quo;
   logic [31:0]                divisor;
   logic                       q_neg;
   logic                       r_neg;

   logic                       a_sext;
   logic                       b_sext;
   logic [32:0]                mul_a;
   logic [32:0]                mul_b;
   logic [63:0]                product;
   logic [31:0]                mul_result;

   logic                       div_signed;
   logic                       a_neg;
   logic                       b_neg;
   logic [31:0]                abs_a;
   logic [31:0]                abs_b;
   logic                       div_by_zero;
   logic [32:0]                shifted;
   logic                       fits;
   logic [31:0]                rem_next;
   logic [31:0]                q_final;
   logic [31:0]                r_final;
   logic [31:0]                div_result;
`ifdef MULDIV_DIV_EARLY_EN
   logic                       sgn_ovf;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake.
   // The unit accepts only when nothing is in flight: in IDLE, or in DONE
   // while the previous result is on the CDB. This allows back-to-back
   // operations without an idle cycle. A flush always wins and blocks a
   // same-cycle accept.
   always_comb begin
      state_next = state;
      in_ready   = ((state == IDLE) || (state == DONE)) && !flush;
      accept     = in_valid && in_ready;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_next = in_multop[2] ? DIV : MUL;
            end else begin
               state_next = IDLE;
            end
         end
         MUL: begin
            if (mul_cnt == 2'd0) begin
               state_next = DONE;
            end
         end
         DIV: begin
            if (div_step == DIV_FINAL_STEP) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   assign resp_valid = (state == DONE);

   // Multiply datapath.
   // Each operand is extended to 33 bits according to its signedness. The
   // extended operands are then sign-extended to 64 bits and multiplied
   // modulo 2^64. Only product bits [63:0] are ever returned, so this gives
   // the same bits as the full 66-bit signed product.
   always_comb begin
      a_sext     = (op == 3'd1) || (op == 3'd2);
      b_sext     = (op == 3'd1);
      mul_a      = {a_sext & opa[31], opa};
      mul_b      = {b_sext & opb[31], opb};
      product    = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
      mul_result = (op[1:0] == 2'd0) ? product[31:0] : product[63:32];
   end

   // Divide datapath.
   // The quotient sign is suppressed for divide-by-zero, so the all-ones
   // magnitude from the loop is returned unchanged. Signed overflow needs
   // no special handling: |A| = 0x80000000 and |B| = 1 give that quotient
   // with a positive sign.
   always_comb begin
      div_signed  = !op[0];
      a_neg       = div_signed & opa[31];
      b_neg       = div_signed & opb[31];
      abs_a       = a_neg ? (32'd0 - opa) : opa;
      abs_b       = b_neg ? (32'd0 - opb) : opb;
      div_by_zero = (opb == 32'd0);
      shifted     = {rem, quo[31]};
      fits        = (shifted >= {1'b0, divisor});
      rem_next    = fits ? (shifted[31:0] - divisor) : shifted[31:0];
      q_final     = q_neg ? (32'd0 - quo) : quo;
      r_final     = r_neg ? (32'd0 - rem) : rem;
      div_result  = op[1] ? r_final : q_final;
`ifdef MULDIV_DIV_EARLY_EN
      sgn_ovf     = div_signed && (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
`endif
   end

   // Operation latch and multi-cycle engines.
   // These registers need no reset: they are only read while state is MUL
   // or DIV, and those states are always entered through an accept that
   // loads them. The quotient register starts out holding the dividend,
   // which is shifted out MSB-first as the quotient bits shift in.
   always_ff @(posedge clk) begin
      if (accept) begin
         op       <= in_multop;
         opa      <= in_rs1_data;
         opb      <= in_rs2_data;
         op_rd    <= in_rd_addr;
         op_rob   <= in_rob_idx;
         mul_cnt  <= MUL_CNT_INIT;
         div_step <= 6'd0;
      end else if (state == MUL) begin
         if (mul_cnt != 2'd0) begin
            mul_cnt <= mul_cnt - 2'd1;
         end
      end else if (state == DIV) begin
         if (div_step == 6'd0) begin
            divisor <= abs_b;
            q_neg   <= (a_neg ^ b_neg) & !div_by_zero;
            r_neg   <= a_neg;
`ifdef MULDIV_DIV_EARLY_EN
            if (div_by_zero || sgn_ovf) begin
               quo      <= div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
               rem      <= div_by_zero ? abs_a : 32'd0;
               div_step <= DIV_FINAL_STEP;
            end else begin
               quo      <= abs_a;
               rem      <= 32'd0;
               div_step <= 6'd1;
            end
`else
            quo      <= abs_a;
            rem      <= 32'd0;
            div_step <= 6'd1;
`endif
         end else if (div_step != DIV_FINAL_STEP) begin
            rem      <= rem_next;
            quo      <= {quo[30:0], fits};
            div_step <= div_step + 6'd1;
         end
      end
   end

   // Response registers.
   // These load only on the edge that enters DONE. A flush on that edge
   // drops the result, so the previous values stay on the CDB lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data    <= 32'd0;
         resp_rd_addr <= 5'd0;
         resp_rob_idx <= '0;
      end else if (!flush) begin
         if ((state == MUL) && (mul_cnt == 2'd0)) begin
            resp_data    <= mul_result;
            resp_rd_addr <= op_rd;
            resp_rob_idx <= op_rob;
         end else if ((state == DIV) && (div_step == DIV_FINAL_STEP)) begin
            resp_data    <= div_result;
            resp_rd_addr <= op_rd;
            resp_rob_idx <= op_rob;
         end
      end
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

RV32M execution unit sitting directly downstream of the multiply/divide reservation station. It accepts one operand-ready instruction at a time, computes any of the eight M-extension operations, and broadcasts a single-cycle result onto the CDB multiply lane (data, destination register, ROB index). Multiplies use a fixed-latency pipeline. Divides use an iterative radix-2 restoring engine.

## Interface
Parameters:
- MUL_LATENCY, 2, cycles from accept to result for MUL/MULH/MULHSU/MULHU; legal range 1..4
- ROB_IDX_WIDTH, 5, width of ROB index tag

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous abort of any in-flight operation
- in_valid  in  1  reservation station presents an operand-ready instruction
- in_ready  out  1  unit can accept this cycle
- in_multop  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1_data  in  32  operand A
- in_rs2_data  in  32  operand B
- in_rd_addr  in  5  destination architectural register
- in_rob_idx  in  ROB_IDX_WIDTH  destination ROB entry
- resp_valid  out  1  CDB multiply-lane valid, one-cycle pulse
- resp_data  out  32  result
- resp_rd_addr  out  5  copy of accepted in_rd_addr
- resp_rob_idx  out  ROB_IDX_WIDTH  copy of accepted in_rob_idx

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Accept occurs when in_valid && in_ready at an edge. The unit latches multop, rd, rob_idx and operands.
- in_ready = (state==IDLE || state==DONE) && !flush. Only one operation is in flight at a time.
- IDLE/DONE -> MUL on an accepted multop 0..3. A stage counter loads MUL_LATENCY-1.
- IDLE/DONE -> DIV on an accepted multop 4..7.
- MUL operands are sign- or zero-extended to 33 bits per op: MULH is s*s, MULHSU is s*u, MULHU is u*u. The 66-bit product is formed and returned as follows:
  - MUL returns bits [31:0].
  - The other multiply ops return bits [63:32].
- DIV operation:
  - Signed ops take absolute values; record the quotient sign (signA^signB) and the remainder sign (signA).
  - 32 iterations of shift/subtract on a 33-bit partial remainder, then one finalize cycle applies the sign correction.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero: quotient is 0xFFFFFFFF and remainder is the dividend, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000 and remainder is 0.
- MUL/DIV -> DONE when the result is ready. In DONE, resp_* are driven with resp_valid=1 for exactly one cycle.
- DONE -> IDLE the next cycle if no new accept occurs; otherwise DONE goes directly to MUL/DIV.
- resp_data, resp_rd_addr and resp_rob_idx hold their last values while resp_valid=0.
- rd_addr 0 is not special-cased; the result is broadcast as computed.
- flush: at the next edge, state becomes IDLE, any pending result is discarded, and resp_valid=0 that cycle. No accept occurs in a cycle where flush=1.

## Timing
- Accept at edge E0. resp_valid is high during the cycle after edge E_N:
  - Multiply ops: N = MUL_LATENCY.
  - Divide ops: N = 34 (1 setup, 32 iterate, 1 finalize).
- Back-to-back operation: an accept in the DONE cycle starts the next op with no bubble. Throughput for multiplies is one op per MUL_LATENCY cycles.
- Reset values (with rst held at an edge, visible the following cycle):
  - state IDLE
  - resp_valid 0, resp_data 0, resp_rd_addr 0, resp_rob_idx 0
  - in_ready 1
- rst mid-operation aborts identically to flush and takes priority over flush and accept.
- in_* inputs are sampled only at the accept edge. Changes to them afterward have no effect.

## Configuration
- MULDIV_DIV_EARLY_EN defined: divide by zero and signed overflow skip the iteration loop. The result is produced with N = 2 (setup, then DONE).
- MULDIV_DIV_EARLY_EN undefined: every divide takes N = 34. The iteration datapath must naturally produce the specified special-case values.
- Result values are identical in both builds; only latency differs.

## Test plan
- Reset then MUL 7*6, rd=5, rob=3 -> after MUL_LATENCY cycles: one-cycle resp_valid, data 42, rd 5, rob 3. in_ready is 0 during the op.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each at exactly 34 cycles. DIVU 100/7 -> 14 and REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Latency is 2 with MULDIV_DIV_EARLY_EN defined, 34 without.
- Flush at cycle 10 of a DIV -> no resp_valid, in_ready=1 the next cycle. A following MUL 3*3 returns 9 with correct latency.
- Back-to-back: present MUL 2*3 and keep in_valid high with DIVU 9/3 -> the second accept happens in the DONE cycle of the first. Results 6 then 3 appear with no idle cycle between the accept and the divide start.
